stack_alu_sequencer: RTL and testbench

Instruction-issuing initiator for the stack-based ALU. It holds a small program of {opcode, operand} words loaded by a host, and on start issues them one by one on the ALU opcode/input_data interface. It captures each ALU result and overflow flag, and tracks stack depth to stop on illegal programs. It sits between a host/controller and the stack ALU instance.

---
 rtl/stack_alu_pkg.sv | 20 ++
 rtl/stack_alu_sequencer_if.sv | 16 +
 rtl/stack_alu_prog_mem.sv | 21 ++
 rtl/stack_alu_sequencer.sv | 153 +++++++++++++++
 tb/tb_stack_alu_sequencer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_alu_pkg.sv
// Shared opcodes, instruction field widths and FSM state encoding for the
// stack ALU sequencer.
package stack_alu_pkg;
  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b100;
  localparam logic [OPC_W-1:0] OP_MUL  = 3'b101;
  localparam logic [OPC_W-1:0] OP_PUSH = 3'b110;
  localparam logic [OPC_W-1:0] OP_POP  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_CAPTURE,
    S_DONE
  } state_t;
endpackage

// File: rtl/stack_alu_sequencer_if.sv
// Opcode/data bus between the sequencer (master) and the stack ALU (slave).
interface stack_alu_sequencer_if
  import stack_alu_pkg::*;
#(
  parameter int N = 8
);
  logic [OPC_W-1:0] alu_opcode;
  logic [N-1:0]     alu_input_data;
  logic [N-1:0]     alu_output_data;
  logic             alu_overflow;

  modport master (output alu_opcode, alu_input_data,
                  input  alu_output_data, alu_overflow);
  modport slave  (input  alu_opcode, alu_input_data,
                  output alu_output_data, alu_overflow);
endinterface

// File: rtl/stack_alu_prog_mem.sv
// Program buffer: synchronous write, registered read of {opcode, operand} words.
module stack_alu_prog_mem
  import stack_alu_pkg::*;
#(
  parameter int N          = 8,
  parameter int PROG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(PROG_DEPTH)-1:0] waddr,
  input  logic [OPC_W+N-1:0]            wdata,
  input  logic [$clog2(PROG_DEPTH)-1:0] raddr,
  output logic [OPC_W+N-1:0]            rdata
);
  logic [OPC_W+N-1:0] mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/stack_alu_sequencer.sv
// Runs a host-loaded program on the stack ALU, one instruction per
// FETCH/ISSUE/CAPTURE triple, stopping on HALT or a stack depth violation.
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N           = 8,
  parameter int PROG_DEPTH  = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [OPC_W+N-1:0]            prog_wdata,
  input  logic [$clog2(PROG_DEPTH):0]   prog_len,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [N-1:0]                  result,
  output logic                          ovf_sticky,
  output logic [$clog2(PROG_DEPTH):0]   pc,
  stack_alu_sequencer_if.master         alu
);
  localparam int AW = $clog2(PROG_DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = $clog2(STACK_DEPTH) + 1;

  state_t           state;
  logic [PW-1:0]    len;
  logic [PW-1:0]    len_clamped;
  logic [PW-1:0]    pc_inc;
  logic [DW-1:0]    depth;
  logic [OPC_W-1:0] ir_op;
  logic [AW-1:0]    rd_addr;
  logic [OPC_W+N-1:0] rd_data;
  logic [OPC_W-1:0] fetch_op;
  logic [N-1:0]     fetch_operand;
  logic             depth_err;

  assign len_clamped   = (prog_len > PW'(PROG_DEPTH)) ? PW'(PROG_DEPTH) : prog_len;
  assign pc_inc        = pc + PW'(1);
  assign fetch_op      = rd_data[OPC_W+N-1:N];
  assign fetch_operand = rd_data[N-1:0];

  // Address the instruction the next FETCH will consume, so the registered read lands on time.
  always_comb begin
    case (state)
      S_CAPTURE:      rd_addr = pc_inc[AW-1:0];
      S_IDLE, S_DONE: rd_addr = '0;
      default:        rd_addr = pc[AW-1:0];
    endcase
  end

  stack_alu_prog_mem #(.N(N), .PROG_DEPTH(PROG_DEPTH)) u_prog_mem (
    .clk   (clk),
    .we    (prog_we && !busy),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    depth_err = 1'b0;
    case (fetch_op)
      OP_PUSH:        depth_err = (depth == DW'(STACK_DEPTH));
      OP_POP:         depth_err = (depth == '0);
      OP_ADD, OP_MUL: depth_err = (depth < DW'(2));
      default:        depth_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      len                <= '0;
      pc                 <= '0;
      depth              <= '0;
      ir_op              <= OP_NOP;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      result             <= '0;
      ovf_sticky         <= 1'b0;
      alu.alu_opcode     <= OP_NOP;
      alu.alu_input_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len        <= len_clamped;
            pc         <= '0;
            depth      <= '0;
            error      <= 1'b0;
            ovf_sticky <= 1'b0;
            if (prog_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
              busy  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          ir_op <= fetch_op;
          if (fetch_op == OP_HALT || depth_err) begin
            error <= depth_err;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state              <= S_ISSUE;
            alu.alu_opcode     <= fetch_op;
            alu.alu_input_data <= (fetch_op == OP_PUSH) ? fetch_operand : '0;
          end
        end
        S_ISSUE: begin
          alu.alu_opcode     <= OP_NOP;
          alu.alu_input_data <= '0;
          case (ir_op)
            OP_PUSH:                depth <= depth + DW'(1);
            OP_POP, OP_ADD, OP_MUL: depth <= depth - DW'(1);
            default:                depth <= depth;
          endcase
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (ir_op == OP_ADD || ir_op == OP_MUL) begin
            result     <= alu.alu_output_data;
            ovf_sticky <= ovf_sticky | alu.alu_overflow;
          end else if (ir_op == OP_POP) begin
            result <= alu.alu_output_data;
          end
          pc <= pc_inc;
          if (pc_inc == len) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: a behavioural ALU on the bus, a program-level
// reference model producing a per-cycle expected trace, directed and random runs.
module tb_stack_alu_sequencer;
  import stack_alu_pkg::*;

  localparam int N  = 8;
  localparam int PD = 16;
  localparam int SD = 8;
  localparam int AW = 4;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [N+2:0]  prog_wdata = '0;
  logic [PW-1:0] prog_len = '0;
  logic          start = 1'b0;
  logic          busy, done, error, ovf_sticky;
  logic [N-1:0]  result;
  logic [PW-1:0] pc;

  stack_alu_sequencer_if #(.N(N)) alu_bus ();

  stack_alu_sequencer #(.N(N), .PROG_DEPTH(PD), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start),
    .busy(busy), .done(done), .error(error), .result(result),
    .ovf_sticky(ovf_sticky), .pc(pc), .alu(alu_bus.master)
  );

  always #5 clk = ~clk;

  // ALU arithmetic: {signed overflow, N-bit truncated result}
  function automatic logic [N:0] alu_calc(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] p;
    logic [N-1:0] s;
    if (op == OP_ADD) begin
      s = a + b;
      return {(a[N-1] == b[N-1]) && (s[N-1] != a[N-1]), s};
    end
    p = $signed(a) * $signed(b);
    s = p[N-1:0];
    return {p != {{N{s[N-1]}}, s}, s};
  endfunction

  // Behavioural stack ALU: acts on the presented opcode, output valid next cycle.
  logic [N-1:0] astk[$];
  logic [N-1:0] sa, sb;
  logic [N:0]   sr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_bus.alu_output_data <= '0;
      alu_bus.alu_overflow    <= 1'b0;
      astk.delete();
    end else begin
      case (alu_bus.alu_opcode)
        OP_PUSH: begin
          astk.push_back(alu_bus.alu_input_data);
          alu_bus.alu_output_data <= alu_bus.alu_input_data;
        end
        OP_POP: if (astk.size() > 0) alu_bus.alu_output_data <= astk.pop_back();
        OP_ADD, OP_MUL: if (astk.size() >= 2) begin
          sa = astk.pop_back();
          sb = astk.pop_back();
          sr = alu_calc(alu_bus.alu_opcode, sa, sb);
          astk.push_back(sr[N-1:0]);
          alu_bus.alu_output_data <= sr[N-1:0];
          alu_bus.alu_overflow    <= sr[N];
        end
        default: ;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct packed {
    logic         busy;
    logic         done;
    logic [2:0]   op;
    logic [N-1:0] data;
  } cyc_t;

  logic [N+2:0] shadow [PD];
  cyc_t         exp_q[$];
  logic [N-1:0] m_result = '0;
  logic         m_ovf, m_err;
  int           m_pc;

  // Interpret the program: expected per-cycle bus trace plus end-of-run outputs.
  function automatic void model_run(input int len_in);
    int len;
    logic [2:0]   op;
    logic [N-1:0] opd, a, b;
    logic [N:0]   r;
    logic [N-1:0] stk[$];
    len = (len_in > PD) ? PD : len_in;
    exp_q.delete();
    m_ovf = 1'b0;
    m_err = 1'b0;
    m_pc  = 0;
    while (m_pc < len) begin
      op  = shadow[m_pc][N+2:N];
      opd = shadow[m_pc][N-1:0];
      if ((op == OP_PUSH && stk.size() == SD) || (op == OP_POP && stk.size() == 0) ||
          ((op == OP_ADD || op == OP_MUL) && stk.size() < 2))
        m_err = 1'b1;
      if (m_err || op == OP_HALT) begin
        exp_q.push_back('{1'b1, 1'b0, OP_NOP, '0});
        break;
      end
      exp_q.push_back('{1'b1, 1'b0, OP_NOP, '0});
      exp_q.push_back('{1'b1, 1'b0, op, (op == OP_PUSH) ? opd : '0});
      exp_q.push_back('{1'b1, 1'b0, OP_NOP, '0});
      case (op)
        OP_PUSH: stk.push_back(opd);
        OP_POP:  m_result = stk.pop_back();
        OP_ADD, OP_MUL: begin
          a = stk.pop_back();
          b = stk.pop_back();
          r = alu_calc(op, a, b);
          stk.push_back(r[N-1:0]);
          m_result = r[N-1:0];
          m_ovf    = m_ovf | r[N];
        end
        default: ;
      endcase
      m_pc++;
    end
    exp_q.push_back('{1'b0, 1'b1, OP_NOP, '0});
    exp_q.push_back('{1'b0, 1'b0, OP_NOP, '0});
  endfunction

  logic cmp_en = 1'b0;
  int   cyc_idx = 0;

  always @(negedge clk) begin
    if (cmp_en && cyc_idx < exp_q.size()) begin
      check($sformatf("busy@%0d", cyc_idx), 32'(busy), 32'(exp_q[cyc_idx].busy));
      check($sformatf("done@%0d", cyc_idx), 32'(done), 32'(exp_q[cyc_idx].done));
      check($sformatf("opcode@%0d", cyc_idx), 32'(alu_bus.alu_opcode), 32'(exp_q[cyc_idx].op));
      check($sformatf("indata@%0d", cyc_idx), 32'(alu_bus.alu_input_data), 32'(exp_q[cyc_idx].data));
      if (exp_q[cyc_idx].done) begin
        check("end_error", 32'(error), 32'(m_err));
        check("end_result", 32'(result), 32'(m_result));
        check("end_ovf", 32'(ovf_sticky), 32'(m_ovf));
        check("end_pc", 32'(pc), 32'(m_pc));
      end
      cyc_idx++;
    end
  end

  function automatic logic [N+2:0] ins(input logic [2:0] op, input logic [N-1:0] v);
    return {op, v};
  endfunction

  task automatic load(input int a, input logic [N+2:0] w);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = AW'(a); prog_wdata = w;
    shadow[a] = w;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask

  // Start a run; optionally fire start and a buffer write while busy, which must both be ignored.
  task automatic run(input int len, input bit poke);
    model_run(len);
    @(negedge clk);
    prog_len = PW'(len);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc_idx = 0;
    cmp_en  = 1'b1;
    for (int i = 0; i < 200 && cyc_idx < exp_q.size(); i++) begin
      @(negedge clk);
      #1;
      if (poke && i == 3 && exp_q.size() > 4 && exp_q[3].busy) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_wdata = (N+3)'($urandom);
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
    end
    start = 1'b0; prog_we = 1'b0;
    check("run_timeout", 32'(cyc_idx), 32'(exp_q.size()));
    cmp_en = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < PD; a++) shadow[a] = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf_sticky), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_opcode", 32'(alu_bus.alu_opcode), 32'(OP_NOP));
    check("rst_indata", 32'(alu_bus.alu_input_data), 32'd0);
    rst = 1'b0;

    load(0, ins(OP_PUSH, 8'd10)); load(1, ins(OP_PUSH, 8'd20)); load(2, ins(OP_ADD, 8'd0));
    run(3, 1'b0);
    check("t1_trace_len", 32'(exp_q.size()), 32'd11);
    check("t1_result", 32'(result), 32'd30);
    check("t1_ovf", 32'(ovf_sticky), 32'd0);
    run(3, 1'b1);
    check("t1_poke_result", 32'(result), 32'd30);

    load(0, ins(OP_PUSH, 8'd3)); load(1, ins(OP_PUSH, 8'd4));
    load(2, ins(OP_MUL, 8'd0));  load(3, ins(OP_POP, 8'd0));
    run(3, 1'b0);
    check("t2_mul_result", 32'(result), 32'd12);
    run(4, 1'b0);
    check("t2_pop_result", 32'(result), 32'd12);
    check("t2_error", 32'(error), 32'd0);

    load(0, ins(OP_PUSH, 8'h7F)); load(1, ins(OP_PUSH, 8'h01)); load(2, ins(OP_ADD, 8'd0));
    run(3, 1'b0);
    check("t3_add_result", 32'(result), 32'h80);
    check("t3_add_ovf", 32'(ovf_sticky), 32'd1);
    load(0, ins(OP_PUSH, 8'h80)); load(1, ins(OP_PUSH, 8'h02)); load(2, ins(OP_MUL, 8'd0));
    run(3, 1'b0);
    check("t3_mul_result", 32'(result), 32'h00);
    check("t3_mul_ovf", 32'(ovf_sticky), 32'd1);

    load(0, ins(OP_ADD, 8'd0));
    run(1, 1'b0);
    check("t4_add_error", 32'(error), 32'd1);
    check("t4_trace_len", 32'(exp_q.size()), 32'd3);
    repeat (3) @(negedge clk);
    check("t4_error_held", 32'(error), 32'd1);
    for (int a = 0; a < 9; a++) load(a, ins(OP_PUSH, 8'(a + 1)));
    run(9, 1'b0);
    check("t4_push_error", 32'(error), 32'd1);
    check("t4_push_pc", 32'(pc), 32'd8);

    load(0, ins(OP_PUSH, 8'd5)); load(1, ins(OP_HALT, 8'd0)); load(2, ins(OP_PUSH, 8'd6));
    run(3, 1'b0);
    check("t5_halt_pc", 32'(pc), 32'd1);
    check("t5_halt_error", 32'(error), 32'd0);
    run(0, 1'b0);
    check("t5_zero_trace_len", 32'(exp_q.size()), 32'd2);

    // Reset during the second ISSUE, then rerun from pc 0.
    load(0, ins(OP_PUSH, 8'd10)); load(1, ins(OP_PUSH, 8'd20)); load(2, ins(OP_ADD, 8'd0));
    @(negedge clk);
    prog_len = PW'(3); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_pre_opcode", 32'(alu_bus.alu_opcode), 32'(OP_PUSH));
    check("t6_pre_indata", 32'(alu_bus.alu_input_data), 32'd20);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_opcode", 32'(alu_bus.alu_opcode), 32'(OP_NOP));
    check("t6_rst_pc", 32'(pc), 32'd0);
    check("t6_rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_result = '0;
    run(3, 1'b1);
    check("t6_rerun_result", 32'(result), 32'd30);

    for (int r = 0; r < 30; r++) begin
      for (int a = 0; a < PD; a++) begin
        int k;
        logic [2:0] op;
        k = $urandom_range(0, 19);
        if (k < 7)       op = OP_PUSH;
        else if (k < 9)  op = OP_ADD;
        else if (k < 11) op = OP_MUL;
        else if (k < 14) op = OP_POP;
        else if (k < 17) op = OP_NOP;
        else if (k < 19) op = 3'($urandom_range(2, 3));
        else             op = OP_HALT;
        load(a, ins(op, 8'($urandom)));
      end
      run($urandom_range(0, 20), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
